// File: rtl/line_job_scheduler_pkg.sv
// Shared types and constants for the line job scheduler: FSM state encoding,
// default coordinate width and the layout of a command word.
package line_job_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRAW  = 2'd2
  } state_e;

  localparam int CW_DEF = 4;
  localparam int CMDW   = 4 * CW_DEF;
  localparam int PIXW   = 2 * CW_DEF;

  localparam int FLD_X0 = 0;
  localparam int FLD_Y0 = 1;
  localparam int FLD_X1 = 2;
  localparam int FLD_Y1 = 3;

  // Command word is {x0,y0,x1,y1} with x0 in the MSBs.
  function automatic int fld_lsb(input int cw, input int fld);
    return (3 - fld) * cw;
  endfunction

endpackage

// File: rtl/bresenham_stepper.sv
// Bresenham line engine: loads a command, then advances one pixel per step
// until the current point equals the end point.
module bresenham_stepper
  import line_job_scheduler_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [4*CW-1:0] i_cmd,
  output logic [2*CW-1:0] o_cur_xy,
  output logic            o_at_end
);

  logic [CW-1:0]        w_x0, w_y0, w_x1, w_y1;
  logic [CW:0]          w_dx_ld;
  logic [CW-1:0]        w_ady;
  logic signed [CW+1:0] w_dy_ld, w_err_ld;

  logic [CW-1:0]        r_x, r_y, r_x1, r_y1;
  logic [CW:0]          r_dx;
  logic signed [CW+1:0] r_dy, r_err;
  logic                 r_sx_neg, r_sy_neg;

  logic signed [CW+2:0] w_e2;
  logic                 w_go_x, w_go_y;
  logic signed [CW+1:0] w_add_x, w_add_y, w_err_step;

  assign w_x0 = i_cmd[fld_lsb(CW, FLD_X0) +: CW];
  assign w_y0 = i_cmd[fld_lsb(CW, FLD_Y0) +: CW];
  assign w_x1 = i_cmd[fld_lsb(CW, FLD_X1) +: CW];
  assign w_y1 = i_cmd[fld_lsb(CW, FLD_Y1) +: CW];

  assign w_dx_ld  = (w_x1 >= w_x0) ? {1'b0, w_x1 - w_x0} : {1'b0, w_x0 - w_x1};
  assign w_ady    = (w_y1 >= w_y0) ? (w_y1 - w_y0) : (w_y0 - w_y1);
  assign w_dy_ld  = -$signed({2'b00, w_ady});
  assign w_err_ld = $signed({1'b0, w_dx_ld}) + w_dy_ld;

  // Both axis decisions use the same pre-update error doubled.
  assign w_e2       = {r_err, 1'b0};
  assign w_go_x     = (w_e2 >= $signed({r_dy[CW+1], r_dy}));
  assign w_go_y     = (w_e2 <= $signed({2'b00, r_dx}));
  assign w_add_x    = w_go_x ? r_dy : '0;
  assign w_add_y    = w_go_y ? $signed({1'b0, r_dx}) : '0;
  assign w_err_step = r_err + w_add_x + w_add_y;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= '0;
      r_y      <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_err    <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
    end else if (i_load) begin
      r_x      <= w_x0;
      r_y      <= w_y0;
      r_x1     <= w_x1;
      r_y1     <= w_y1;
      r_dx     <= w_dx_ld;
      r_dy     <= w_dy_ld;
      r_err    <= w_err_ld;
      r_sx_neg <= !(w_x0 < w_x1);
      r_sy_neg <= !(w_y0 < w_y1);
    end else if (i_step) begin
      r_err <= w_err_step;
      if (w_go_x) r_x <= r_sx_neg ? (r_x - CW'(1)) : (r_x + CW'(1));
      if (w_go_y) r_y <= r_sy_neg ? (r_y - CW'(1)) : (r_y + CW'(1));
    end
  end

  assign o_cur_xy = {r_x, r_y};
  assign o_at_end = (r_x == r_x1) && (r_y == r_y1);

endmodule

// File: rtl/line_job_scheduler.sv
// Round-robin scheduler sharing one Bresenham engine between NREQ command
// sources; streams tagged pixels to a backpressured sink.
module line_job_scheduler
  import line_job_scheduler_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int CW   = CW_DEF,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      cmd_valid,
  input  logic [NREQ*4*CW-1:0] cmd_data,
  output logic [NREQ-1:0]      cmd_ready,
  input  logic                 abort,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [2*CW-1:0]      pix_xy,
  output logic [IDW-1:0]       pix_src,
  output logic                 pix_last,
  output logic                 busy,
  output logic [7:0]           lines_done
);

  localparam int CMD_W = 4 * CW;

  state_e            r_state, w_state_nxt;
  logic [IDW-1:0]    r_rr_ptr, w_rr_nxt;
  logic [CMD_W-1:0]  r_cmd, w_sel_cmd;
  logic [IDW-1:0]    r_src, w_gnt_idx;
  logic              r_pix_valid, w_pix_valid_nxt;
  logic [7:0]        r_lines_done;

  logic [NREQ-1:0]   w_grant;
  logic              w_found, w_accept;
  logic              w_hs, w_load, w_step, w_line_done;
  logic [2*CW-1:0]   w_cur_xy;
  logic              w_at_end;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_grant   = '0;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_rr_nxt  = r_rr_ptr;
    w_sel_cmd = '0;
    if (r_state == ST_IDLE && !abort) begin
      for (int k = 0; k < NREQ; k++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!w_found && cmd_valid[i] && (i == (int'(r_rr_ptr) + k) % NREQ)) begin
            w_found    = 1'b1;
            w_grant[i] = 1'b1;
            w_gnt_idx  = IDW'(i);
            w_rr_nxt   = IDW'((i + 1) % NREQ);
          end
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_sel_cmd = cmd_data[i*CMD_W +: CMD_W];
    end
  end

  // Reset forces IDLE asynchronously, so gate ready to keep it low during reset.
  assign cmd_ready = w_grant & {NREQ{rst_n}};
  assign w_accept  = w_found;
  assign w_hs      = r_pix_valid & pix_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_pix_valid_nxt = r_pix_valid;
    w_load          = 1'b0;
    w_step          = 1'b0;
    w_line_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        w_load = 1'b1;
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt     = ST_DRAW;
          w_pix_valid_nxt = 1'b1;
        end
      end
      ST_DRAW: begin
        w_step = w_hs && !w_at_end;
        if (abort) begin
          w_state_nxt     = ST_IDLE;
          w_pix_valid_nxt = 1'b0;
        end else if (w_hs && w_at_end) begin
          w_state_nxt     = ST_IDLE;
          w_pix_valid_nxt = 1'b0;
          w_line_done     = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_pix_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_cmd        <= '0;
      r_src        <= '0;
      r_pix_valid  <= 1'b0;
      r_lines_done <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pix_valid <= w_pix_valid_nxt;
      if (w_accept) begin
        r_cmd    <= w_sel_cmd;
        r_src    <= w_gnt_idx;
        r_rr_ptr <= w_rr_nxt;
      end
      if (w_line_done) r_lines_done <= r_lines_done + 8'd1;
    end
  end

  bresenham_stepper #(.CW(CW)) u_stepper (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_cmd    (r_cmd),
    .o_cur_xy (w_cur_xy),
    .o_at_end (w_at_end)
  );

  // The engine's current point is the pixel on offer; last is only meaningful while valid.
  assign pix_valid  = r_pix_valid;
  assign pix_xy     = w_cur_xy;
  assign pix_src    = r_src;
  assign pix_last   = r_pix_valid & w_at_end;
  assign busy       = (r_state != ST_IDLE);
  assign lines_done = r_lines_done;

endmodule

// File: tb/tb_line_job_scheduler.sv
// Scoreboard bench for line_job_scheduler: a line model queues expected pixels
// at command accept; a negedge monitor checks arbitration, pixels and status.
module tb_line_job_scheduler;
  import line_job_scheduler_pkg::*;

  localparam int NREQ = 2;
  localparam int CW   = CW_DEF;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [PIXW-1:0] xy;
    logic [IDW-1:0]  src;
    logic            last;
  } pix_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      cmd_valid;
  logic [NREQ*CMDW-1:0] cmd_data;
  logic [NREQ-1:0]      cmd_ready;
  logic                 abort;
  logic                 pix_valid;
  logic                 pix_ready;
  logic [PIXW-1:0]      pix_xy;
  logic [IDW-1:0]       pix_src;
  logic                 pix_last;
  logic                 busy;
  logic [7:0]           lines_done;

  pix_t           exp_q[$];
  logic [CMDW-1:0] pend_q[NREQ][$];
  bit             acc_flag[NREQ];
  int             n_tests = 0, n_fail = 0;
  int             cyc = 0, acc_cyc = 0, line_cnt = 0, exp_lines = 0, model_rr = 0;
  bit             m_active = 0, chk_done = 0, chk_abort = 0;
  int             rdy_mode = 0;

  always #5 clk = ~clk;

  line_job_scheduler #(.NREQ(NREQ), .CW(CW), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .abort      (abort),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_xy     (pix_xy),
    .pix_src    (pix_src),
    .pix_last   (pix_last),
    .busy       (busy),
    .lines_done (lines_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CMDW-1:0] mk(input int x0, input int y0, input int x1, input int y1);
    return {CW'(x0), CW'(y0), CW'(x1), CW'(y1)};
  endfunction

  // Reference line model on plain integers.
  task automatic push_line(input logic [CMDW-1:0] c, input int src);
    int x0, y0, x1, y1, x, y, dx, dy, sx, sy, err, e2;
    bit lst;
    x0 = int'(c[4*CW-1 -: CW]);
    y0 = int'(c[3*CW-1 -: CW]);
    x1 = int'(c[2*CW-1 -: CW]);
    y1 = int'(c[CW-1 -: CW]);
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y0 - y1 : y1 - y0;
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x = x0;
    y = y0;
    for (int n = 0; n < 64; n++) begin
      lst = (x == x1) && (y == y1);
      exp_q.push_back('{xy: {CW'(x), CW'(y)}, src: IDW'(src), last: lst});
      if (lst) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // Stimulus driver: presents each requester's queue head, retires it after accept.
  initial begin
    cmd_valid = '0;
    cmd_data  = '0;
    pix_ready = 1'b1;
    abort     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_flag[i]) begin
          if (pend_q[i].size() > 0) void'(pend_q[i].pop_front());
          acc_flag[i] = 0;
        end
        cmd_valid[i] = (pend_q[i].size() > 0);
        if (pend_q[i].size() > 0) cmd_data[i*CMDW +: CMDW] = pend_q[i][0];
      end
      if (rdy_mode == 0) pix_ready = 1'b1;
      else if (rdy_mode == 1) pix_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [NREQ-1:0] exp_rdy;
    int idx;
    bit prev_valid, prev_ready, prev_abort, lst;
    pix_t cur, prev_pix, e;
    prev_valid = 0; prev_ready = 0; prev_abort = 0; prev_pix = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 0; prev_ready = 0; prev_abort = 0;
        chk_done = 0; chk_abort = 0;
        continue;
      end
      cyc++;
      if (chk_done) begin
        check("busy_after_last", 32'(busy), 32'(0));
        check("lines_done", 32'(lines_done), 32'(exp_lines));
        chk_done = 0;
      end
      if (chk_abort) begin
        check("abort_pix_valid", 32'(pix_valid), 32'(0));
        check("abort_pix_last", 32'(pix_last), 32'(0));
        check("abort_lines_done", 32'(lines_done), 32'(exp_lines));
        chk_abort = 0;
      end
      exp_rdy = '0;
      if (!m_active && !abort) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (model_rr + k) % NREQ;
          if (exp_rdy == '0 && cmd_valid[idx]) exp_rdy[idx] = 1'b1;
        end
      end
      if (cmd_valid != '0 || cmd_ready != '0) check("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
      for (int i = 0; i < NREQ; i++) begin
        if (cmd_valid[i] && cmd_ready[i]) begin
          push_line(cmd_data[i*CMDW +: CMDW], i);
          model_rr = (i + 1) % NREQ;
          m_active = 1;
          acc_cyc = cyc;
          acc_flag[i] = 1;
          line_cnt = 0;
        end
      end
      cur = '{xy: pix_xy, src: pix_src, last: pix_last};
      if (pix_valid) begin
        if (!prev_valid) check("first_pixel_latency", 32'(cyc - acc_cyc), 32'(2));
        else if (!prev_ready && !prev_abort) check("stall_stable", 32'(cur), 32'(prev_pix));
        if (pix_ready) begin
          lst = 0;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pixel: got 0x%0h with no pixel expected at %0t", cur, $time);
          end else begin
            e = exp_q.pop_front();
            lst = e.last;
            check("pix_xy", 32'(pix_xy), 32'(e.xy));
            check("pix_src", 32'(pix_src), 32'(e.src));
            check("pix_last", 32'(pix_last), 32'(e.last));
          end
          line_cnt++;
          if (lst && !abort) begin
            exp_lines = (exp_lines + 1) % 256;
            m_active = 0;
            chk_done = 1;
          end
        end
      end
      if (abort && m_active) begin
        exp_q.delete();
        m_active = 0;
        chk_abort = 1;
      end
      prev_valid = pix_valid;
      prev_ready = pix_ready;
      prev_abort = abort;
      prev_pix = cur;
    end
  end

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk);
      #2;
      if (pend_q[0].size() == 0 && pend_q[1].size() == 0 && exp_q.size() == 0 &&
          !m_active && cmd_valid == '0) begin
        ok = 1;
        break;
      end
    end
    check("wait_idle_in_budget", 32'(ok), 32'(1));
  endtask

  task automatic wait_pix(input int n_pix);
    bit ok;
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #2;
      if (m_active && line_cnt >= n_pix) begin
        ok = 1;
        break;
      end
    end
    check("wait_pixels_in_budget", 32'(ok), 32'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    // Both requesters valid from reset with 2-pixel lines: grants alternate 0,1,0,1.
    pend_q[0].push_back(mk(0, 0, 1, 0));
    pend_q[0].push_back(mk(2, 2, 3, 3));
    pend_q[0].push_back(mk(9, 9, 8, 8));
    pend_q[1].push_back(mk(5, 5, 5, 6));
    pend_q[1].push_back(mk(7, 1, 6, 0));
    pend_q[1].push_back(mk(0, 15, 1, 14));
    repeat (3) @(posedge clk);
    #2;
    check("reset_cmd_valid_driven", 32'(cmd_valid), 32'(2'b11));
    check("reset_cmd_ready", 32'(cmd_ready), 32'(0));
    check("reset_pix_valid", 32'(pix_valid), 32'(0));
    check("reset_pix_xy", 32'(pix_xy), 32'(0));
    check("reset_pix_src", 32'(pix_src), 32'(0));
    check("reset_pix_last", 32'(pix_last), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_lines_done", 32'(lines_done), 32'(0));
    #1 rst_n = 1'b1;
    wait_idle(200);

    // Directed lines on requester 0.
    pend_q[0].push_back(mk(0, 0, 3, 1));
    pend_q[0].push_back(mk(5, 5, 5, 5));
    pend_q[0].push_back(mk(3, 0, 0, 0));
    pend_q[0].push_back(mk(2, 4, 2, 1));
    wait_idle(200);

    // Backpressure mid-line.
    pend_q[0].push_back(mk(0, 0, 7, 3));
    wait_pix(3);
    rdy_mode = 2;
    pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    pix_ready = 1'b1;
    rdy_mode = 0;
    wait_idle(200);

    // Random lines from random requesters with random backpressure.
    rdy_mode = 1;
    for (int n = 0; n < 40; n++) begin
      pend_q[$urandom_range(0, NREQ - 1)].push_back(
        mk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)));
    end
    wait_idle(4000);
    rdy_mode = 0;

    // Abort after the 2nd pixel; the queued command from requester 1 follows.
    pend_q[0].push_back(mk(0, 0, 15, 15));
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #2;
      if (m_active) begin ok = 1; break; end
    end
    check("abort_line_accepted", 32'(ok), 32'(1));
    pend_q[1].push_back(mk(1, 2, 4, 3));
    wait_pix(2);
    abort = 1'b1;
    @(posedge clk);
    #2;
    abort = 1'b0;
    wait_idle(200);

    // Abort held in IDLE blocks acceptance.
    abort = 1'b1;
    pend_q[0].push_back(mk(1, 1, 2, 2));
    repeat (4) @(posedge clk);
    #2;
    check("abort_blocks_accept", 32'(busy), 32'(0));
    abort = 1'b0;
    wait_idle(200);

    // Asynchronous reset mid-line.
    pend_q[1].push_back(mk(0, 0, 15, 15));
    wait_pix(3);
    check("pre_reset_src", 32'(pix_src), 32'(1));
    #1;
    rst_n = 1'b0;
    pend_q[0].delete();
    pend_q[1].delete();
    for (int i = 0; i < NREQ; i++) acc_flag[i] = 0;
    exp_q.delete();
    m_active = 0;
    model_rr = 0;
    exp_lines = 0;
    cmd_valid = '1;
    #1;
    check("midreset_cmd_ready", 32'(cmd_ready), 32'(0));
    check("midreset_pix_valid", 32'(pix_valid), 32'(0));
    check("midreset_pix_xy", 32'(pix_xy), 32'(0));
    check("midreset_pix_src", 32'(pix_src), 32'(0));
    check("midreset_pix_last", 32'(pix_last), 32'(0));
    check("midreset_busy", 32'(busy), 32'(0));
    check("midreset_lines_done", 32'(lines_done), 32'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("post_reset_busy", 32'(busy), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_job_scheduler.md
Name: line_job_scheduler

Overview:
- Shares one Bresenham line-drawing engine between NREQ requesters, each submitting line commands (x0,y0,x1,y1) over a valid/ready handshake.
- Round-robin arbitration picks the next requester; the block runs the engine to completion and streams pixels out with backpressure, tagged with the source ID and an end-of-line flag.
- Sits between the command sources (host registers or pattern generators) and the pixel sink (framebuffer writer or output pins).

Parameters:
- NREQ, 2, number of requesters; legal 2..4.
- CW, 4, coordinate width in bits; command word is 4*CW bits.
- IDW, 2, width of the source ID; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  NREQ  per-requester command valid
- cmd_data  in  NREQ*4*CW  per requester, slice i = {x0,y0,x1,y1}, x0 in the MSBs
- cmd_ready  out  NREQ  per-requester accept
- abort  in  1  synchronous cancel of the current line
- pix_valid  out  1  pixel valid
- pix_ready  in  1  sink ready
- pix_xy  out  2*CW  {x,y}
- pix_src  out  IDW  ID of the requester that owns the current line
- pix_last  out  1  final pixel of the line
- busy  out  1  high in SETUP or DRAW
- lines_done  out  8  count of completed lines; wraps at 255

Behaviour:
- Reset values: pix_valid=0, pix_xy=0, pix_src=0, pix_last=0, busy=0, lines_done=0, rr_ptr=0, FSM=IDLE. cmd_ready=0 while rst_n is low.
- FSM states: IDLE, SETUP, DRAW.
- IDLE:
  - cmd_ready is combinational and one-hot at most: it is high only for the first valid requester found searching from rr_ptr upward, modulo NREQ, and only when abort=0.
  - On accept (cmd_valid[i] & cmd_ready[i]) in cycle T: latch the command and src=i, set rr_ptr=(i+1) mod NREQ, go to SETUP.
- SETUP (T+1):
  - dx = |x1-x0|, unsigned, CW+1 bits.
  - dy = -|y1-y0|, signed, CW+2 bits.
  - sx = +1 if x0<x1, else -1. sy = +1 if y0<y1, else -1.
  - err = dx+dy, signed, CW+2 bits. x=x0, y=y0.
  - Go to DRAW with pix_valid=1 and pix_xy={x0,y0} registered, so the first pixel is visible at T+2.
  - pix_last is set in the same cycle if x0==x1 and y0==y1.
- DRAW:
  - Outputs stay stable while pix_valid & !pix_ready.
  - On handshake of a non-last pixel: e2 = 2*err, signed, CW+3 bits.
  - If e2 >= dy: err += dy and x += sx.
  - If e2 <= dx: err += dx and y += sy.
  - Both updates apply in the same cycle when both conditions hold (err receives both addends).
  - Register the next pixel; pix_last = (next x == x1 and next y == y1).
  - Throughput is 1 pixel/cycle with pix_ready held high. A line emits max(dx,|dy|)+1 pixels.
- On handshake with pix_last=1: lines_done++, pix_valid=0, return to IDLE. The next accept is possible in the following cycle.
- abort:
  - In SETUP or DRAW: next cycle FSM=IDLE, pix_valid=0, pix_last=0, no lines_done increment. A pixel handshaking in the abort cycle still counts as delivered.
  - In IDLE: blocks acceptance.
- Coordinates never wrap: the algorithm terminates exactly on (x1,y1). The arithmetic widths above guarantee no overflow for all CW-bit inputs.
- Asynchronous reset mid-line: immediate return to reset values; the command in flight is discarded.
- cmd_data of a non-granted requester is ignored; requesters must hold data stable while valid.

Decomposition:
- Shared package:
  - FSM state enum.
  - CW default.
  - helper constants CMDW=4*CW and PIXW=2*CW.
  - function for the coordinate field offsets in cmd_data.
- Sub-module: bresenham_stepper. It holds x, y, err, dx, dy, sx, sy, x1, y1 and has ports load, step, cur_xy, and at_end.
- The scheduler owns the arbiter, FSM, pixel output register and lines_done counter.

Test Plan:
- Requester 0 sends (0,0)->(3,1), pix_ready=1 -> pix_xy 0x00,0x10,0x21,0x31 on consecutive cycles; first pixel 2 cycles after accept; pix_last only on 0x31; pix_src=0; lines_done=1.
- Point line (5,5)->(5,5) -> single pixel 0x55 with pix_last=1; FSM back to IDLE the next cycle.
- Reverse/vertical lines:
  - (3,0)->(0,0) -> 0x30,0x20,0x10,0x00.
  - (2,4)->(2,1) -> 0x24,0x23,0x22,0x21.
- Both requesters valid from reset with 2-pixel lines -> grant order 0,1,0,1; cmd_ready never high on both; pix_src follows the same order.
- Backpressure: drop pix_ready for 3 cycles mid-line -> pix_xy and pix_last stable, no pixel skipped or duplicated.
- abort after the 2nd pixel of (0,0)->(15,15) -> pix_valid low the next cycle, lines_done unchanged, the next queued command is accepted. A separate run asserts rst_n low mid-line -> all outputs at reset values.
